priority_encoder8to3_q: RTL and testbench
=========================================

# priority_encoder8to3_q

Registered 8-to-3 priority encoder with a pending-request register and a valid/ready output handshake; the inverse of the team's 3-to-8 decoder. It collects up to eight independent request lines, holds them as sticky pending bits, and emits the index of the highest-priority pending bit as a 3-bit code to a downstream consumer. Each accepted code clears its pending bit. Intended as the interrupt/event encoder in front of any block that drives a 3-to-8 decoder.

## Interface

- HIGH_FIRST, default 1: 1 = bit 7 highest priority; 0 = bit 0 highest priority.

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- E  input  1  enable; gates capture of D and launch of new codes
- D  input  8  request lines, level-sampled each cycle while E=1
- clr  input  8  per-bit pending clear mask, one cycle pulse or level
- rdy  input  1  consumer ready
- Y  output  3  encoded index of presented request
- V  output  1  Y valid
- pend  output  8  pending register (direct register output)
- ovf  output  1  sticky overrun flag

## Operation

- Pending register update each cycle, bitwise: pend_next = (pend & ~clr & ~acc) | (E ? D : 0).
  - acc = one-hot of Y when V & rdy, else 0.
  - A set from D wins over clr and acc on the same bit in the same cycle.
- Two-state output FSM: IDLE, PRESENT.
  - IDLE: if E=1 and pend != 0, load Y with the priority-encoded index of the current registered pend (per HIGH_FIRST), set V=1, go to PRESENT. Otherwise hold V=0 and keep Y at its last value.
  - PRESENT: Y and V are held stable until V & rdy.
    - On accept: clear pend[Y] (via acc), set V=0, go to IDLE.
    - Y never changes while V=1, even if a higher-priority bit arrives or clr removes pend[Y]. In that case the code is still delivered, and acc on an already-clear bit is harmless.
- E=0:
  - D is ignored and no new code is launched.
  - A code already in PRESENT still completes its handshake.
  - clr still applies.
- ovf:
  - Set when, in any cycle with E=1, D[i]=1, pend[i]=1, and bit i is not cleared by clr or acc that cycle (lost event).
  - Sticky; cleared only by rst.
- Reset (sync, any state including mid-PRESENT): pend=8'h00, Y=3'd0, V=0, ovf=0, FSM=IDLE. A presented but unaccepted code is discarded.

## Timing

- Request latency: D[i] high in cycle t (E=1) → pend[i]=1 in cycle t+1 → V=1 with Y=i in cycle t+2, if the FSM is IDLE at t+1.
- Accept in cycle k (V=1, rdy=1) → V=0 and pend[Y]=0 in cycle k+1 → next V=1 no earlier than cycle k+2.
  - Sustained throughput: one code per 2 cycles.
- Priority is evaluated only at the IDLE→PRESENT launch, on the registered pend value.
- rdy may be asserted before V. The handshake completes in the first cycle where both are high.
- All outputs are registered. No combinational path from any input to Y, V, pend or ovf.

## Test plan

- **Reset:** drive random D/clr, then assert rst for 1 cycle → the next cycle shows pend=8'h00, V=0, Y=0, ovf=0. Repeat with rst asserted while V=1 → V=0 the following cycle and the code is never delivered.
- **Single request:** D=8'h10 for one cycle at t, rdy=1 → pend=8'h10 at t+1; V=1, Y=4 at t+2; V=0, pend=8'h00 at t+3.
- **Priority ordering:** D=8'h85 one cycle, rdy=1 constantly.
  - HIGH_FIRST=1 → Y sequence 7, 2, 0 with V pattern 1,0,1,0,1.
  - HIGH_FIRST=0 → Y sequence 0, 2, 7.
- **Backpressure/stability:** pend=8'h08, rdy=0 for 5 cycles → V=1, Y=3 held constant. Inject D=8'h80 during the stall → Y stays 3 until rdy=1; after the bubble, V=1, Y=7.
- **Collisions:**
  - D[2]=1 while pend[2]=1 and no clear → ovf=1, still 1 after 10 idle cycles.
  - D[5]=1 and clr[5]=1 in the same cycle → pend[5]=1 next cycle.
  - clr=8'hFF while V=1, Y=6 → Y=6 still delivered on rdy, pend=8'h00.
- **Enable gating:** E=0, D=8'hFF for 4 cycles → pend unchanged, V stays 0, ovf unchanged. Drop E to 0 while V=1 → handshake still completes on rdy=1.

Source files
------------

// File: rtl/priority_encoder8to3_q.sv
// Registered 8-to-3 priority encoder with sticky pending requests and a
// valid/ready output handshake. Requests collect in a pending register, the
// highest-priority pending bit is launched as a 3-bit code, and each accepted
// code clears its own pending bit. A lost event (a request arriving on a bit
// that is already pending and not being cleared) sets a sticky overrun flag.
module priority_encoder8to3_q #(
  parameter int unsigned HIGH_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic [7:0] D,
  input  logic [7:0] clr,
  input  logic       rdy,
  output logic [2:0] Y,
  output logic       V,
  output logic [7:0] pend,
  output logic       ovf
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t     state;
  logic [7:0] acc;
  logic [7:0] set_bits;
  logic [7:0] pend_next;
  logic       lost;

  // Index of the winning pending bit; the last match in the scan order wins,
  // so scanning upward favours bit 7 and scanning downward favours bit 0.
  function automatic logic [2:0] encode(input logic [7:0] req);
    logic [2:0] idx;
    idx = 3'd0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          idx = 3'(i);
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (req[i]) begin
          idx = 3'(i);
        end
      end
    end
    return idx;
  endfunction

  // Next pending value: acceptance and clr drop bits, new requests re-set them
  // with precedence; a request on a surviving pending bit is a lost event.
  always_comb begin
    acc       = 8'h00;
    set_bits  = 8'h00;
    pend_next = 8'h00;
    lost      = 1'b0;
    if (V && rdy) begin
      acc = 8'b1 << Y;
    end
    if (E) begin
      set_bits = D;
    end
    pend_next = (pend & ~clr & ~acc) | set_bits;
    lost      = |(set_bits & pend & ~clr & ~acc);
  end

  // Pending register, overrun flag and the IDLE/PRESENT output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= 8'h00;
      ovf   <= 1'b0;
      Y     <= 3'd0;
      V     <= 1'b0;
      state <= IDLE;
    end else begin
      pend <= pend_next;
      if (lost) begin
        ovf <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (E && (pend != 8'h00)) begin
            Y     <= encode(pend);
            V     <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (V && rdy) begin
            V     <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          V     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_encoder8to3_q.sv
// Directed testbench for priority_encoder8to3_q. Two instances share the
// stimulus: one with bit 7 highest priority, one with bit 0 highest.
module tb_priority_encoder8to3_q;

  logic       clk;
  logic       rst;
  logic       E;
  logic [7:0] D;
  logic [7:0] clr;
  logic       rdy;

  logic [2:0] y_h;
  logic       v_h;
  logic [7:0] pend_h;
  logic       ovf_h;
  logic [2:0] y_l;
  logic       v_l;
  logic [7:0] pend_l;
  logic       ovf_l;

  int vectors;
  int miscompares;

  priority_encoder8to3_q #(.HIGH_FIRST(1)) dut_h (
    .clk  (clk),
    .rst  (rst),
    .E    (E),
    .D    (D),
    .clr  (clr),
    .rdy  (rdy),
    .Y    (y_h),
    .V    (v_h),
    .pend (pend_h),
    .ovf  (ovf_h)
  );

  priority_encoder8to3_q #(.HIGH_FIRST(0)) dut_l (
    .clk  (clk),
    .rst  (rst),
    .E    (E),
    .D    (D),
    .clr  (clr),
    .rdy  (rdy),
    .Y    (y_l),
    .V    (v_l),
    .pend (pend_l),
    .ovf  (ovf_l)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then step past the next rising edge so the
  // registered outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic e_v, input logic [7:0] d_v,
                               input logic [7:0] clr_v, input logic rdy_v,
                               input logic rst_v);
    E   = e_v;
    D   = d_v;
    clr = clr_v;
    rdy = rdy_v;
    rst = rst_v;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    vectors     = 0;
    miscompares = 0;
    E   = 1'b0;
    D   = 8'h00;
    clr = 8'h00;
    rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Reset after activity, with a code presented and ovf set.
    $display("[TB] reset scenario");
    applyStimulus(1'b1, 8'h5A, 8'h01, 1'b0, 1'b0);
    checkOutput("rst_pre_pend", pend_h, 8'h5A);
    applyStimulus(1'b1, 8'h3C, 8'h01, 1'b0, 1'b0);
    checkOutput("rst_pre_v", 8'(v_h), 8'h01);
    checkOutput("rst_pre_y", 8'(y_h), 8'h06);
    checkOutput("rst_pre_ovf", 8'(ovf_h), 8'h01);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("rst_pend", pend_h, 8'h00);
    checkOutput("rst_v", 8'(v_h), 8'h00);
    checkOutput("rst_y", 8'(y_h), 8'h00);
    checkOutput("rst_ovf", 8'(ovf_h), 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("rst_discard_v1", 8'(v_h), 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("rst_discard_v2", 8'(v_h), 8'h00);
    checkOutput("rst_discard_pend", pend_h, 8'h00);

    // Single request: latency of one cycle to pend, two to V.
    $display("[TB] single request");
    applyStimulus(1'b1, 8'h10, 8'h00, 1'b1, 1'b0);
    checkOutput("single_pend", pend_h, 8'h10);
    checkOutput("single_v0", 8'(v_h), 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("single_v1", 8'(v_h), 8'h01);
    checkOutput("single_y", 8'(y_h), 8'h04);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("single_v_after", 8'(v_h), 8'h00);
    checkOutput("single_pend_after", pend_h, 8'h00);

    // Priority ordering for both priority directions.
    $display("[TB] priority ordering");
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h85, 8'h00, 1'b1, 1'b0);
    checkOutput("prio_pend", pend_h, 8'h85);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("prio_h_v1", 8'(v_h), 8'h01);
    checkOutput("prio_h_y1", 8'(y_h), 8'h07);
    checkOutput("prio_l_y1", 8'(y_l), 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("prio_h_v2", 8'(v_h), 8'h00);
    checkOutput("prio_h_pend2", pend_h, 8'h05);
    checkOutput("prio_l_pend2", pend_l, 8'h84);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("prio_h_v3", 8'(v_h), 8'h01);
    checkOutput("prio_h_y3", 8'(y_h), 8'h02);
    checkOutput("prio_l_y3", 8'(y_l), 8'h02);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("prio_h_v4", 8'(v_h), 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("prio_h_v5", 8'(v_h), 8'h01);
    checkOutput("prio_h_y5", 8'(y_h), 8'h00);
    checkOutput("prio_l_v5", 8'(v_l), 8'h01);
    checkOutput("prio_l_y5", 8'(y_l), 8'h07);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("prio_h_v6", 8'(v_h), 8'h00);
    checkOutput("prio_h_pend6", pend_h, 8'h00);

    // Backpressure: Y held through a stall even when bit 7 arrives.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h08, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_v_launch", 8'(v_h), 8'h01);
    checkOutput("bp_y_launch", 8'(y_h), 8'h03);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_y_s1", 8'(y_h), 8'h03);
    applyStimulus(1'b1, 8'h80, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_y_s2", 8'(y_h), 8'h03);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_y_s3", 8'(y_h), 8'h03);
    checkOutput("bp_pend_s3", pend_h, 8'h88);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("bp_v_s4", 8'(v_h), 8'h01);
    checkOutput("bp_y_s4", 8'(y_h), 8'h03);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("bp_v_bubble", 8'(v_h), 8'h00);
    checkOutput("bp_pend_bubble", pend_h, 8'h80);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("bp_v_next", 8'(v_h), 8'h01);
    checkOutput("bp_y_next", 8'(y_h), 8'h07);

    // Lost event sets sticky ovf.
    $display("[TB] collisions");
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h04, 8'h00, 1'b0, 1'b0);
    checkOutput("ovf_first", 8'(ovf_h), 8'h00);
    applyStimulus(1'b1, 8'h04, 8'h00, 1'b0, 1'b0);
    checkOutput("ovf_set", 8'(ovf_h), 8'h01);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("ovf_sticky", 8'(ovf_h), 8'h01);

    // Set wins over clr on the same bit, and a cleared re-request is not lost.
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h20, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h20, 8'h20, 1'b0, 1'b0);
    checkOutput("setclr_pend", pend_h, 8'h20);
    checkOutput("setclr_ovf", 8'(ovf_h), 8'h00);

    // clr of the presented bit does not cancel delivery.
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h40, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'hFF, 1'b0, 1'b0);
    checkOutput("clrall_pend", pend_h, 8'h00);
    checkOutput("clrall_v", 8'(v_h), 8'h01);
    checkOutput("clrall_y", 8'(y_h), 8'h06);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("clrall_v_done", 8'(v_h), 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("clrall_v_idle", 8'(v_h), 8'h00);
    checkOutput("clrall_ovf", 8'(ovf_h), 8'h00);

    // Enable gating: D ignored and no launch while E=0.
    $display("[TB] enable gating");
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h02, 8'h00, 1'b0, 1'b0);
    checkOutput("en_pend_init", pend_h, 8'h02);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
      checkOutput("en_off_pend", pend_h, 8'h02);
      checkOutput("en_off_v", 8'(v_h), 8'h00);
    end
    checkOutput("en_off_ovf", 8'(ovf_h), 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("en_launch_v", 8'(v_h), 8'h01);
    checkOutput("en_launch_y", 8'(y_h), 8'h01);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("en_hold_v", 8'(v_h), 8'h01);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("en_done_v", 8'(v_h), 8'h00);
    checkOutput("en_done_pend", pend_h, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
